// File: rtl/time_display_driver_if.sv
// time_display_driver_if
// Bundles the signals between the clock counter / control panel and the
// 7-segment display driver.
//   master : drives the time/date fields and the view/edit controls,
//            observes the display lines.
//   slave  : the display driver; reads fields and controls, drives the display.
// Signals:
//   mode_time    0 = time view, 1 = date view
//   manual_set   edit mode active
//   select_item  field being edited (001 sec .. 110 year)
//   second, minute, hour, day (6b), month (4b), year (14b) binary fields
//   seg          {g,f,e,d,c,b,a}, active-low
//   an           one-hot active-low digit enables, an[7] leftmost
//   dp           decimal point, active-low
interface time_display_driver_if;
  logic        mode_time;
  logic        manual_set;
  logic [2:0]  select_item;
  logic [5:0]  second;
  logic [5:0]  minute;
  logic [5:0]  hour;
  logic [5:0]  day;
  logic [3:0]  month;
  logic [13:0] year;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;

  modport master (
    output mode_time, manual_set, select_item,
    output second, minute, hour, day, month, year,
    input  seg, an, dp
  );

  modport slave (
    input  mode_time, manual_set, select_item,
    input  second, minute, hour, day, month, year,
    output seg, an, dp
  );
endinterface

// File: rtl/time_display_driver.sv
// time_display_driver
// Converts the binary time/date fields to BCD with a single shared
// double-dabble engine and scans them onto an 8-digit common-anode
// 7-segment display. All digits are committed together at the end of a
// 56-cycle conversion round so a half-updated value is never shown. The
// field being edited blinks while manual set is active.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    time_display_driver_if.slave (fields and controls in, seg/an/dp out)
// Parameters:
//   SCAN_DIV   clocks per digit slot of the multiplex scan
//   BLINK_DIV  clocks per blink phase
module time_display_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  time_display_driver_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [2:0] {
    CAPTURE,
    LOAD,
    SHIFT,
    STORE,
    COMMIT
  } conv_state_t;

  conv_state_t state, next_state;

  logic [2:0]  field_idx;
  logic [3:0]  shift_cnt;
  logic [3:0]  field_last;

  logic [5:0]  snap_sec, snap_min, snap_hour, snap_day;
  logic [3:0]  snap_month;
  logic [13:0] snap_year;

  logic [15:0] bcd, bcd_adj;
  logic [13:0] bin, load_value;

  logic [7:0]  stage_sec, stage_min, stage_hour, stage_day, stage_month;
  logic [15:0] stage_year;
  logic [7:0]  disp_sec, disp_min, disp_hour, disp_day, disp_month;
  logic [15:0] disp_year;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic               prev_manual;
  logic [2:0]         prev_select;
  logic               blink_clear;

  logic [3:0] digit_val;
  logic       use_dash;
  logic       owned;
  logic       blank;

  logic [6:0] seg_q;
  logic [7:0] an_q;
  logic       dp_q;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Last shift index of the field being converted (width - 1).
  always_comb begin
    field_last = 4'd5;
    case (field_idx)
      3'd4:    field_last = 4'd3;
      3'd5:    field_last = 4'd13;
      default: field_last = 4'd5;
    endcase
  end

  // Binary value left-aligned in the 14-bit shifter so that every field
  // feeds its MSB into the BCD register first.
  always_comb begin
    load_value = '0;
    case (field_idx)
      3'd0:    load_value = {snap_sec,   8'd0};
      3'd1:    load_value = {snap_min,   8'd0};
      3'd2:    load_value = {snap_hour,  8'd0};
      3'd3:    load_value = {snap_day,   8'd0};
      3'd4:    load_value = {snap_month, 10'd0};
      3'd5:    load_value = snap_year;
      default: load_value = '0;
    endcase
  end

  // Double-dabble correction: any nibble of 5 or more gets 3 added before
  // the shift so it carries correctly into the next decade.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Converter state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAPTURE;
    end else begin
      state <= next_state;
    end
  end

  // Converter sequencing: capture, six load/shift/store passes, commit.
  always_comb begin
    next_state = state;
    case (state)
      CAPTURE: next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (shift_cnt == field_last) next_state = STORE;
      STORE:   next_state = (field_idx == 3'd5) ? COMMIT : LOAD;
      COMMIT:  next_state = CAPTURE;
      default: next_state = CAPTURE;
    endcase
  end

  // Converter datapath: snapshot, shift register, staging and committed digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_idx   <= '0;
      shift_cnt   <= '0;
      snap_sec    <= '0;
      snap_min    <= '0;
      snap_hour   <= '0;
      snap_day    <= '0;
      snap_month  <= '0;
      snap_year   <= '0;
      bcd         <= '0;
      bin         <= '0;
      stage_sec   <= '0;
      stage_min   <= '0;
      stage_hour  <= '0;
      stage_day   <= '0;
      stage_month <= '0;
      stage_year  <= '0;
      disp_sec    <= '0;
      disp_min    <= '0;
      disp_hour   <= '0;
      disp_day    <= '0;
      disp_month  <= '0;
      disp_year   <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          field_idx  <= '0;
          snap_sec   <= bus.second;
          snap_min   <= bus.minute;
          snap_hour  <= bus.hour;
          snap_day   <= bus.day;
          snap_month <= bus.month;
          snap_year  <= (bus.year > 14'd9999) ? 14'd9999 : bus.year;
        end
        LOAD: begin
          bcd       <= '0;
          bin       <= load_value;
          shift_cnt <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          shift_cnt  <= shift_cnt + 4'd1;
        end
        STORE: begin
          case (field_idx)
            3'd0:    stage_sec   <= bcd[7:0];
            3'd1:    stage_min   <= bcd[7:0];
            3'd2:    stage_hour  <= bcd[7:0];
            3'd3:    stage_day   <= bcd[7:0];
            3'd4:    stage_month <= bcd[7:0];
            default: stage_year  <= bcd;
          endcase
          field_idx <= field_idx + 3'd1;
        end
        COMMIT: begin
          disp_sec   <= stage_sec;
          disp_min   <= stage_min;
          disp_hour  <= stage_hour;
          disp_day   <= stage_day;
          disp_month <= stage_month;
          disp_year  <= stage_year;
        end
        default: ;
      endcase
    end
  end

  // Multiplex scan: advance to the next digit every SCAN_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Blink restarts in the visible phase whenever editing starts or the
  // selected field changes, so the new field is shown before it blanks.
  assign blink_clear = !bus.manual_set
                    || (bus.manual_set != prev_manual)
                    || (bus.select_item != prev_select);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      prev_manual <= 1'b0;
      prev_select <= '0;
    end else begin
      prev_manual <= bus.manual_set;
      prev_select <= bus.select_item;
      if (blink_clear) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Digit content for the active slot in the live view.
  always_comb begin
    digit_val = 4'd0;
    use_dash  = 1'b0;
    if (!bus.mode_time) begin
      case (scan_idx)
        3'd7:    digit_val = disp_hour[7:4];
        3'd6:    digit_val = disp_hour[3:0];
        3'd4:    digit_val = disp_min[7:4];
        3'd3:    digit_val = disp_min[3:0];
        3'd1:    digit_val = disp_sec[7:4];
        3'd0:    digit_val = disp_sec[3:0];
        default: use_dash  = 1'b1;
      endcase
    end else begin
      case (scan_idx)
        3'd7:    digit_val = disp_day[7:4];
        3'd6:    digit_val = disp_day[3:0];
        3'd5:    digit_val = disp_month[7:4];
        3'd4:    digit_val = disp_month[3:0];
        3'd3:    digit_val = disp_year[15:12];
        3'd2:    digit_val = disp_year[11:8];
        3'd1:    digit_val = disp_year[7:4];
        default: digit_val = disp_year[3:0];
      endcase
    end
  end

  // Does the active slot belong to the selected field in the live view?
  // Fields not shown in this view, and codes 000/111, own no slot.
  always_comb begin
    owned = 1'b0;
    case ({bus.mode_time, bus.select_item})
      4'b0_001: owned = (scan_idx <= 3'd1);
      4'b0_010: owned = (scan_idx == 3'd3) || (scan_idx == 3'd4);
      4'b0_011: owned = (scan_idx >= 3'd6);
      4'b1_100: owned = (scan_idx >= 3'd6);
      4'b1_101: owned = (scan_idx == 3'd4) || (scan_idx == 3'd5);
      4'b1_110: owned = (scan_idx <= 3'd3);
      default:  owned = 1'b0;
    endcase
  end

  assign blank = bus.manual_set && blink_phase && owned;

  // Registered display outputs; the anode stays one-hot even when blanked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 8'hFF;
      dp_q  <= 1'b1;
    end else begin
      an_q <= ~(8'd1 << scan_idx);
      if (blank) begin
        seg_q <= SEG_BLANK;
        dp_q  <= 1'b1;
      end else begin
        seg_q <= use_dash ? SEG_DASH : seg_of(digit_val);
        dp_q  <= ~(bus.mode_time && ((scan_idx == 3'd6) || (scan_idx == 3'd4)));
      end
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver
// Self-checking bench for time_display_driver with SCAN_DIV=2, BLINK_DIV=8.
// A behavioural model (round timing from cycle arithmetic, digits from
// decimal division, blink phase from run length) predicts seg/an/dp every
// cycle; a table of hand-computed display images and a few hand sequences
// cover reset, scan stepping, saturation, blinking and mid-round reset.
module tb_time_display_driver;

  localparam int SCAN_DIV  = 2;
  localparam int BLINK_DIV = 8;
  localparam int ROUND     = 56;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  time_display_driver_if bus();

  time_display_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic           mode;
    int             sec;
    int             min;
    int             hour;
    int             day;
    int             month;
    int             year;
    logic [7:0][6:0] segs;
    logic [7:0]     dp_n;
  } vec_t;

  vec_t vecs[7];

  int asserts;
  int fails;
  logic chk_en;

  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_cyc;
  int         m_run;
  int         m_snap[6];
  int         m_disp[6];
  logic       m_last_man;
  logic [2:0] m_last_sel;
  logic [6:0] exp_seg;
  logic [7:0] exp_an;
  logic       exp_dp;
  int         m_idx;
  int         m_dval;
  logic       m_dash;
  logic       m_phase;
  logic       m_blank;

  int t_idx;
  int blanks;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic mode, input logic man, input logic [2:0] sel,
                                input int s, input int mi, input int h,
                                input int d, input int mo, input int y);
    bus.mode_time   = mode;
    bus.manual_set  = man;
    bus.select_item = sel;
    bus.second      = 6'(s);
    bus.minute      = 6'(mi);
    bus.hour        = 6'(h);
    bus.day         = 6'(d);
    bus.month       = 4'(mo);
    bus.year        = 14'(y);
  endtask

  function automatic logic field_owns(input logic mode, input logic [2:0] sel, input int idx);
    if (!mode) begin
      case (sel)
        3'b001:  return idx < 2;
        3'b010:  return (idx == 3) || (idx == 4);
        3'b011:  return idx > 5;
        default: return 1'b0;
      endcase
    end else begin
      case (sel)
        3'b100:  return idx > 5;
        3'b101:  return (idx == 4) || (idx == 5);
        3'b110:  return idx < 4;
        default: return 1'b0;
      endcase
    end
  endfunction

  // Reference model: predicts the outputs produced by each clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cyc      = 0;
        m_run      = 0;
        m_last_man = 1'b0;
        m_last_sel = 3'b000;
        for (int i = 0; i < 6; i++) begin
          m_snap[i] = 0;
          m_disp[i] = 0;
        end
        exp_seg = 7'h7F;
        exp_an  = 8'hFF;
        exp_dp  = 1'b1;
      end else begin
        m_cyc++;
        m_idx   = ((m_cyc - 1) / SCAN_DIV) % 8;
        m_phase = ((m_run / BLINK_DIV) % 2) == 1;
        m_dash  = 1'b0;
        m_dval  = 0;
        if (!bus.mode_time) begin
          case (m_idx)
            7: m_dval = m_disp[2] / 10;
            6: m_dval = m_disp[2] % 10;
            4: m_dval = m_disp[1] / 10;
            3: m_dval = m_disp[1] % 10;
            1: m_dval = m_disp[0] / 10;
            0: m_dval = m_disp[0] % 10;
            default: m_dash = 1'b1;
          endcase
        end else begin
          case (m_idx)
            7: m_dval = m_disp[3] / 10;
            6: m_dval = m_disp[3] % 10;
            5: m_dval = m_disp[4] / 10;
            4: m_dval = m_disp[4] % 10;
            3: m_dval = m_disp[5] / 1000;
            2: m_dval = (m_disp[5] / 100) % 10;
            1: m_dval = (m_disp[5] / 10) % 10;
            default: m_dval = m_disp[5] % 10;
          endcase
        end
        m_blank = bus.manual_set && m_phase && field_owns(bus.mode_time, bus.select_item, m_idx);
        exp_an  = ~(8'd1 << m_idx);
        if (m_blank) begin
          exp_seg = 7'h7F;
          exp_dp  = 1'b1;
        end else begin
          exp_seg = m_dash ? 7'h3F : seg_lut[m_dval];
          exp_dp  = !(bus.mode_time && (m_idx == 6 || m_idx == 4));
        end
        if ((m_cyc - 1) % ROUND == 0) begin
          m_snap[0] = int'(bus.second);
          m_snap[1] = int'(bus.minute);
          m_snap[2] = int'(bus.hour);
          m_snap[3] = int'(bus.day);
          m_snap[4] = int'(bus.month);
          m_snap[5] = (int'(bus.year) > 9999) ? 9999 : int'(bus.year);
        end
        if (m_cyc % ROUND == 0) begin
          for (int i = 0; i < 6; i++) m_disp[i] = m_snap[i];
        end
        if (!bus.manual_set || (bus.manual_set != m_last_man) || (bus.select_item != m_last_sel))
          m_run = 0;
        else
          m_run++;
        m_last_man = bus.manual_set;
        m_last_sel = bus.select_item;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check_output("model_an",  bus.an,  exp_an);
        check_output("model_seg", bus.seg, exp_seg);
        check_output("model_dp",  bus.dp,  exp_dp);
      end
    end
  end

  initial begin
    asserts = 0;
    fails   = 0;
    chk_en  = 1'b0;

    vecs[0] = '{1'b0, 59, 5, 23, 1, 1, 2000,
                {7'h24, 7'h30, 7'h3F, 7'h40, 7'h12, 7'h3F, 7'h12, 7'h10}, 8'hFF};
    vecs[1] = '{1'b1, 0, 0, 0, 29, 2, 2024,
                {7'h24, 7'h10, 7'h40, 7'h24, 7'h24, 7'h40, 7'h24, 7'h19}, 8'hAF};
    vecs[2] = '{1'b1, 0, 0, 0, 1, 12, 12000,
                {7'h40, 7'h79, 7'h79, 7'h24, 7'h10, 7'h10, 7'h10, 7'h10}, 8'hAF};
    vecs[3] = '{1'b0, 0, 59, 0, 1, 1, 0,
                {7'h40, 7'h40, 7'h3F, 7'h12, 7'h10, 7'h3F, 7'h40, 7'h40}, 8'hFF};
    vecs[4] = '{1'b1, 0, 0, 0, 31, 7, 9999,
                {7'h30, 7'h79, 7'h40, 7'h78, 7'h10, 7'h10, 7'h10, 7'h10}, 8'hAF};
    vecs[5] = '{1'b1, 0, 0, 0, 15, 10, 1987,
                {7'h79, 7'h12, 7'h79, 7'h40, 7'h79, 7'h10, 7'h00, 7'h78}, 8'hAF};
    vecs[6] = '{1'b0, 48, 37, 16, 1, 1, 0,
                {7'h79, 7'h02, 7'h3F, 7'h30, 7'h78, 7'h3F, 7'h19, 7'h00}, 8'hFF};

    apply_stimulus(1'b0, 1'b0, 3'b000, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_output("rst_seg", bus.seg, 7'h7F);
    check_output("rst_an",  bus.an,  8'hFF);
    check_output("rst_dp",  bus.dp,  1'b1);

    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check_output("first_an",  bus.an,  8'hFE);
    check_output("first_seg", bus.seg, 7'h40);
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      check_output("scan_step_an", bus.an, 8'hFF ^ (8'h01 << (((k - 1) / 2) % 8)));
    end

    $display("[TB] display image vectors");
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      apply_stimulus(vecs[v].mode, 1'b0, 3'b000, vecs[v].sec, vecs[v].min, vecs[v].hour,
                     vecs[v].day, vecs[v].month, vecs[v].year);
      repeat (120) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        t_idx = ((m_cyc - 1) / SCAN_DIV) % 8;
        check_output($sformatf("vec%0d_seg_d%0d", v, t_idx), bus.seg, vecs[v].segs[t_idx]);
        check_output($sformatf("vec%0d_dp_d%0d", v, t_idx), bus.dp, vecs[v].dp_n[t_idx]);
      end
    end

    $display("[TB] off-view selection never blanks");
    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 3'b101, 30, 45, 12, 1, 1, 2000);
    blanks = 0;
    repeat (64) begin
      @(negedge clk);
      if (bus.seg == 7'h7F) blanks++;
    end
    check_output("sel101_no_blank", blanks, 0);

    $display("[TB] blink on minutes, then switch to hours mid-blank");
    @(negedge clk);
    bus.manual_set  = 1'b0;
    @(negedge clk);
    apply_stimulus(1'b0, 1'b1, 3'b010, 59, 5, 23, 1, 1, 2000);
    repeat (44) @(negedge clk);
    bus.select_item = 3'b011;
    repeat (48) @(negedge clk);
    bus.manual_set = 1'b0;

    $display("[TB] reset mid-round");
    repeat (23) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_seg", bus.seg, 7'h7F);
    check_output("midrst_an",  bus.an,  8'hFF);
    check_output("midrst_dp",  bus.dp,  1'b1);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 3'b000, 41, 17, 9, 1, 1, 2000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_an",  bus.an,  8'hFE);
    check_output("post_rst_seg", bus.seg, 7'h40);
    repeat (120) @(negedge clk);

    $display("[TB] randomized stimulus");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: bus.second = 6'($urandom_range(0, 63));
          1: bus.minute = 6'($urandom_range(0, 63));
          2: bus.hour   = 6'($urandom_range(0, 63));
          3: bus.day    = 6'($urandom_range(0, 63));
          4: bus.month  = 4'($urandom_range(0, 15));
          default: bus.year = 14'($urandom_range(0, 16383));
        endcase
      end
      if ($urandom_range(0, 99) == 0) bus.manual_set  = ~bus.manual_set;
      if ($urandom_range(0, 59) == 0) bus.select_item = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 79) == 0) bus.mode_time   = ~bus.mode_time;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/time_display_driver.md
Name: time_display_driver

Overview:
- Consumes the time/date fields produced by the clock counter block and drives an 8-digit multiplexed common-anode 7-segment display.
- Converts each binary field to BCD with one shared sequential double-dabble engine and commits all digits atomically, so the display never shows a partially updated value.
- Blinks the field currently being edited while manual set is active.

Parameters:
- SCAN_DIV, 50000: clocks per digit slot in the multiplex scan (≥1).
- BLINK_DIV, 25000000: clocks per blink phase (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode_time  in  1  0 = time view, 1 = date view
- manual_set  in  1  edit mode active
- select_item  in  3  001 sec, 010 min, 011 hour, 100 day, 101 month, 110 year
- second  in  6  binary seconds
- minute  in  6  binary minutes
- hour  in  6  binary hours
- day  in  6  binary day
- month  in  4  binary month
- year  in  14  binary year
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  8  digit enables, one-hot active-low; an[7] is the leftmost digit
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, rst_n=0):
  - seg=7'h7F, an=8'hFF, dp=1.
  - All committed BCD digits 0.
  - Scan index 0; scan and blink counters 0; blink_phase 0.
  - Converter FSM in CAPTURE.
- Converter FSM, running continuously:
  - CAPTURE (1 cycle): snapshot all six fields. Year is saturated to 9999 if it exceeds 9999.
  - Per field, in the order sec, min, hour, day, month, year:
    - LOAD (1 cycle): clear the BCD shift register and load the binary value.
    - SHIFT (w cycles; w=6,6,6,6,4,14): on each cycle, add 3 to every BCD nibble ≥5, then shift left by 1.
    - STORE (1 cycle): write the result to a staging register.
  - COMMIT (1 cycle): copy the staging registers to the committed registers, then return to CAPTURE.
  - A round is exactly 56 cycles.
  - An input change is displayed within 112 cycles, counted after the next CAPTURE.
  - Input changes during a round are ignored until the next CAPTURE.
- Scan:
  - The scan counter counts 0..SCAN_DIV-1.
  - On wrap, scan_idx increments modulo 8 (7→0).
- Digit map, time view (mode_time=0): d7 hour tens, d6 hour ones, d5 dash, d4 min tens, d3 min ones, d2 dash, d1 sec tens, d0 sec ones. dp=1 on all digits.
- Digit map, date view (mode_time=1): d7 day tens, d6 day ones, d5 month tens, d4 month ones, d3..d0 year thousands..ones. dp=0 while d6 or d4 is active.
- mode_time is used live, not snapshotted.
- Segment codes (hex):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - dash=3F, blank=7F.
- Outputs are registered and recomputed every cycle from scan_idx, the committed digits, mode and blink state.
  - One cycle after reset release: an=8'hFE.
- Blink:
  - The blink counter counts 0..BLINK_DIV-1; on wrap, blink_phase toggles.
  - The blink counter and blink_phase are cleared to 0 on any cycle where:
    - manual_set is 0, or
    - the registered previous manual_set differs from the current value (rising edge), or
    - select_item differs from its value on the previous cycle.
  - While blink_phase=0 the field is visible.
  - Blank condition, all of the following true:
    - manual_set=1,
    - blink_phase=1,
    - the active digit belongs to the selected field in the current view.
  - When blanked: seg=7F, dp=1, an is still driven one-hot.
  - Selecting a field that is not in the current view (e.g. mode 0 with 100), or selecting 000/111, blanks nothing.
- Reset asserted mid-round aborts the conversion immediately. Committed digits return to 0.

Test Plan:
- Reset release, SCAN_DIV=2, all inputs 0 → cycle 1: an=FE, seg=40.
  - an then steps FD, FB, … 7F, FE, one step every 2 cycles.
- mode 0, hour=23, minute=5, second=59; wait 120 cycles → the 8 digits read 2,3,-,0,5,-,5,9 (seg 24,30,3F,40,12,3F,12,10), dp=1 throughout.
- mode 1, day=29, month=2, year=2024 → digits 2,9,0,2,2,0,2,4; dp=0 on d6 and d4 only.
- year=12000 → year digits 9,9,9,9.
  - Change second at round cycle 10 → new value is not shown until after the next COMMIT.
- BLINK_DIV=8, manual_set=1, mode 0, select=010:
  - d4/d3 visible for 8 cycles, then seg=7F for 8 cycles, then alternating.
  - Changing select to 011 mid-blank → phase cleared; hours visible for 8 cycles.
- mode 0 with select=101 and manual_set=1 → no digit ever blanked.
  - rst_n pulsed low mid-round → outputs reset immediately, digits show 0 until the next COMMIT.
